// File: rtl/board_io_ring_if.sv
// Board I/O ring bundle: reset sources, pad pins, LED and amplifier signals.
// master = board/core side that drives the ring inputs; slave = the ring itself.
interface board_io_ring_if #(
    parameter int NUM_PINS = 32,
    parameter int NUM_LEDS = 8
);
    logic                rts;
    logic                ext_res_n;
    logic                cfg_halt;
    logic                nres;
    logic [NUM_PINS-1:0] pin_i;
    logic [NUM_PINS-1:0] pin_in_core;
    logic [NUM_PINS-1:0] pin_out_core;
    logic [NUM_PINS-1:0] pin_dir_core;
    logic [NUM_PINS-1:0] pin_o;
    logic [NUM_PINS-1:0] pin_oe;
    logic [NUM_LEDS-1:0] cog_led_in;
    logic [NUM_LEDS-1:0] led;
    logic                amp_en;

    modport master (
        output rts, ext_res_n, cfg_halt,
        output pin_i, pin_out_core, pin_dir_core, cog_led_in,
        input  nres, pin_in_core, pin_o, pin_oe, led, amp_en
    );

    modport slave (
        input  rts, ext_res_n, cfg_halt,
        input  pin_i, pin_out_core, pin_dir_core, cog_led_in,
        output nres, pin_in_core, pin_o, pin_oe, led, amp_en
    );
endinterface

// File: rtl/board_io_ring.sv
// Board I/O ring between FPGA pads and the Propeller core: reset sequencer,
// pin synchronisers, registered output enables, LED stretchers, amp enable.
// Ports: clk_cog (core clock), res (async active-high reset),
//   io (board_io_ring_if.slave): rts/ext_res_n/cfg_halt -> nres,
//   pin_i -> pin_in_core, pin_out_core/pin_dir_core -> pin_o/pin_oe,
//   cog_led_in -> led, amp_en.
// Optional macro BOARD_IO_GLITCH_FILTER_EN adds a 3-sample pin input filter.
module board_io_ring #(
    parameter int NUM_PINS    = 32,
    parameter int SYNC_STAGES = 2,
    parameter int RESET_HOLD  = 16,
    parameter int NUM_LEDS    = 8,
    parameter int LED_STRETCH = 1000,
    parameter int AMP_PIN     = 10
) (
    input logic            clk_cog,
    input logic            res,
    board_io_ring_if.slave io
);
    localparam int HCW = $clog2(RESET_HOLD + 1);
    localparam int LCW = $clog2(LED_STRETCH + 1);

    typedef enum logic {
        HOLD,
        RUN
    } state_t;

    // Reset-source synchronisers; reset to 0 so a request is pending
    // until the sources have been seen inactive for SYNC_STAGES edges.
    logic [SYNC_STAGES-1:0] rts_sync;
    logic [SYNC_STAGES-1:0] ext_sync;
    logic                   trigger;

    always_ff @(posedge clk_cog or posedge res) begin
        if (res) begin
            rts_sync <= '0;
            ext_sync <= '0;
        end else begin
            rts_sync <= {rts_sync[SYNC_STAGES-2:0], io.rts};
            ext_sync <= {ext_sync[SYNC_STAGES-2:0], io.ext_res_n};
        end
    end

    assign trigger = ~rts_sync[SYNC_STAGES-1] | ~ext_sync[SYNC_STAGES-1];

    // Reset sequencer
    state_t         state;
    state_t         state_nxt;
    logic [HCW-1:0] count;
    logic [HCW-1:0] count_nxt;
    logic           block;

    assign block = trigger | io.cfg_halt;

    always_ff @(posedge clk_cog or posedge res) begin
        if (res) begin
            state <= HOLD;
            count <= '0;
        end else begin
            state <= state_nxt;
            count <= count_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        count_nxt = count;
        unique case (state)
            HOLD: begin
                if (block) begin
                    count_nxt = '0;
                end else if (count == HCW'(RESET_HOLD - 1)) begin
                    state_nxt = RUN;
                    count_nxt = '0;
                end else begin
                    count_nxt = count + HCW'(1);
                end
            end
            RUN: begin
                if (block) begin
                    state_nxt = HOLD;
                    count_nxt = '0;
                end
            end
            default: begin
                state_nxt = HOLD;
                count_nxt = '0;
            end
        endcase
    end

    logic nres_q;
    assign nres_q  = (state == RUN);
    assign io.nres = nres_q;

    // Pad outputs: enables are forced off while the core is in reset
    logic [NUM_PINS-1:0] pin_o_q;
    logic [NUM_PINS-1:0] pin_oe_q;
    logic                amp_q;

    always_ff @(posedge clk_cog or posedge res) begin
        if (res) begin
            pin_o_q  <= '0;
            pin_oe_q <= '0;
            amp_q    <= 1'b0;
        end else begin
            pin_o_q  <= io.pin_out_core;
            pin_oe_q <= nres_q ? io.pin_dir_core : '0;
            amp_q    <= nres_q & io.pin_dir_core[AMP_PIN];
        end
    end

    assign io.pin_o  = pin_o_q;
    assign io.pin_oe = pin_oe_q;
    assign io.amp_en = amp_q;

    // Pin input synchronisers
    logic [NUM_PINS-1:0] psync [SYNC_STAGES];

    always_ff @(posedge clk_cog or posedge res) begin
        if (res) begin
            for (int i = 0; i < SYNC_STAGES; i++) begin
                psync[i] <= '0;
            end
        end else begin
            psync[0] <= io.pin_i;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                psync[i] <= psync[i-1];
            end
        end
    end

`ifdef BOARD_IO_GLITCH_FILTER_EN
    // The synced value plus two older samples must agree; otherwise the
    // last accepted value is held.
    logic [NUM_PINS-1:0] hist1;
    logic [NUM_PINS-1:0] hist2;
    logic [NUM_PINS-1:0] held;
    logic [NUM_PINS-1:0] agree;
    logic [NUM_PINS-1:0] filt;

    always_comb begin
        agree = ~(psync[SYNC_STAGES-1] ^ hist1) & ~(hist1 ^ hist2);
        filt  = (agree & psync[SYNC_STAGES-1]) | (~agree & held);
    end

    always_ff @(posedge clk_cog or posedge res) begin
        if (res) begin
            hist1 <= '0;
            hist2 <= '0;
            held  <= '0;
        end else begin
            hist1 <= psync[SYNC_STAGES-1];
            hist2 <= hist1;
            held  <= filt;
        end
    end

    assign io.pin_in_core = filt;
`else
    assign io.pin_in_core = psync[SYNC_STAGES-1];
`endif

    // LED activity stretchers
    logic [LCW-1:0]      led_cnt [NUM_LEDS];
    logic [NUM_LEDS-1:0] led_q;

    always_ff @(posedge clk_cog or posedge res) begin
        if (res) begin
            for (int i = 0; i < NUM_LEDS; i++) begin
                led_cnt[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_LEDS; i++) begin
                if (io.cog_led_in[i]) begin
                    led_cnt[i] <= LCW'(LED_STRETCH);
                end else if (led_cnt[i] != '0) begin
                    led_cnt[i] <= led_cnt[i] - LCW'(1);
                end
            end
        end
    end

    always_comb begin
        led_q = '0;
        for (int i = 0; i < NUM_LEDS; i++) begin
            led_q[i] = (led_cnt[i] != '0);
        end
    end

    assign io.led = led_q;
endmodule

// File: tb/tb_board_io_ring.sv
// Self-checking bench for board_io_ring: directed scenarios plus random
// traffic compared every cycle against a time-window reference model.
module tb_board_io_ring;
    localparam int NP   = 32;
    localparam int NL   = 8;
    localparam int SYNC = 2;
    localparam int HOLD = 16;
    localparam int LS   = 1000;
    localparam int AMP  = 10;

    logic          clk_cog = 1'b0;
    logic          res;
    logic          rts;
    logic          ext_res_n;
    logic          cfg_halt;
    logic [NP-1:0] pin_i;
    logic [NP-1:0] pin_out_core;
    logic [NP-1:0] pin_dir_core;
    logic [NL-1:0] cog_led_in;

    int n_chk  = 0;
    int n_pass = 0;

    always #5 clk_cog = ~clk_cog;

    board_io_ring_if #(.NUM_PINS(NP), .NUM_LEDS(NL)) bus ();

    assign bus.rts          = rts;
    assign bus.ext_res_n    = ext_res_n;
    assign bus.cfg_halt     = cfg_halt;
    assign bus.pin_i        = pin_i;
    assign bus.pin_out_core = pin_out_core;
    assign bus.pin_dir_core = pin_dir_core;
    assign bus.cog_led_in   = cog_led_in;

    board_io_ring #(
        .NUM_PINS   (NP),
        .SYNC_STAGES(SYNC),
        .RESET_HOLD (HOLD),
        .NUM_LEDS   (NL),
        .LED_STRETCH(LS),
        .AMP_PIN    (AMP)
    ) dut (
        .clk_cog(clk_cog),
        .res    (res),
        .io     (bus)
    );

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        if (got !== exp)
            $display("FAIL %s: got %h, expected %h", tag, got, exp);
        else
            n_pass++;
    endtask

    // Reference model: nres is high once HOLD consecutive edges have seen
    // no blocking condition; LEDs are lit within LS edges of a request.
    int            n;
    int            last_blk;
    int            last_led [NL];
    logic          rq [SYNC];
    logic [NP-1:0] ph [SYNC+2];
    logic          m_nres;
    logic [NP-1:0] m_pin_o;
    logic [NP-1:0] m_pin_oe;
    logic          m_amp;
    logic [NP-1:0] m_pic;
    logic [NL-1:0] m_led;

    task automatic model_reset();
        n        = 0;
        last_blk = 0;
        for (int i = 0; i < SYNC; i++) rq[i] = 1'b1;
        for (int i = 0; i < SYNC + 2; i++) ph[i] = '0;
        for (int i = 0; i < NL; i++) last_led[i] = -2 * LS;
        m_nres   = 1'b0;
        m_pin_o  = '0;
        m_pin_oe = '0;
        m_amp    = 1'b0;
        m_pic    = '0;
        m_led    = '0;
    endtask

    task automatic model_edge();
        logic          blk;
        logic          prev;
        logic [NP-1:0] agree;
        if (res) begin
            model_reset();
            return;
        end
        n++;
        blk = rq[SYNC-1] | cfg_halt;
        for (int i = SYNC - 1; i > 0; i--) rq[i] = rq[i-1];
        rq[0] = ~rts | ~ext_res_n;
        if (blk) last_blk = n;
        prev     = m_nres;
        m_nres   = (n - last_blk >= HOLD);
        m_pin_o  = pin_out_core;
        m_pin_oe = prev ? pin_dir_core : '0;
        m_amp    = prev & pin_dir_core[AMP];
        for (int i = 0; i < NL; i++) begin
            if (cog_led_in[i]) last_led[i] = n;
            m_led[i] = (n - last_led[i] < LS);
        end
        for (int i = SYNC + 1; i > 0; i--) ph[i] = ph[i-1];
        ph[0] = pin_i;
`ifdef BOARD_IO_GLITCH_FILTER_EN
        agree = ~(ph[SYNC-1] ^ ph[SYNC]) & ~(ph[SYNC] ^ ph[SYNC+1]);
        m_pic = (agree & ph[SYNC-1]) | (~agree & m_pic);
`else
        agree = '1;
        m_pic = agree & ph[SYNC-1];
`endif
    endtask

    task automatic check_all(input string ph_tag);
        chk({ph_tag, ".nres"}, 32'(bus.nres), 32'(m_nres));
        chk({ph_tag, ".pin_o"}, bus.pin_o, m_pin_o);
        chk({ph_tag, ".pin_oe"}, bus.pin_oe, m_pin_oe);
        chk({ph_tag, ".amp_en"}, 32'(bus.amp_en), 32'(m_amp));
        chk({ph_tag, ".pin_in"}, bus.pin_in_core, m_pic);
        chk({ph_tag, ".led"}, 32'(bus.led), 32'(m_led));
    endtask

    // Inputs are driven at the negedge; one call covers one posedge.
    task automatic tick(input string ph_tag);
        @(posedge clk_cog);
        model_edge();
        #1;
        check_all(ph_tag);
        @(negedge clk_cog);
    endtask

    int   rise;
    int   fall;
    int   lat;
    int   hi;
    logic saw;
    logic other;

    initial begin
        res          = 1'b1;
        rts          = 1'b1;
        ext_res_n    = 1'b1;
        cfg_halt     = 1'b0;
        pin_i        = '0;
        pin_out_core = '0;
        pin_dir_core = '1;
        cog_led_in   = '0;
        model_reset();
        @(negedge clk_cog);
        #1;
        check_all("rst");
        for (int i = 0; i < 3; i++) tick("rst");

        // Startup latency, all pins requested as outputs
        res  = 1'b0;
        rise = -1;
        for (int i = 1; i <= 24; i++) begin
            tick("boot");
            if (rise < 0 && bus.nres) rise = i;
        end
        chk("nres_rise", rise, SYNC + HOLD);

        // One-cycle RTS reset request
        rts  = 1'b0;
        tick("rts");
        rts  = 1'b1;
        fall = bus.nres ? -1 : 1;
        rise = -1;
        for (int i = 2; i <= 40; i++) begin
            tick("rts");
            if (fall < 0 && !bus.nres) fall = i;
            if (fall > 0 && rise < 0 && bus.nres) rise = i;
        end
        chk("rts_fall", fall, SYNC + 1);
        chk("rts_low", rise - fall, HOLD);

        // Amplifier follows pin_oe[AMP]
        pin_dir_core = 32'h0000_0400;
        pin_out_core = 32'h0000_0400;
        tick("amp");
        chk("amp_oe", bus.pin_oe, 32'h0000_0400);
        chk("amp_o", bus.pin_o, 32'h0000_0400);
        chk("amp_on", 32'(bus.amp_en), 1);
        pin_dir_core = '0;
        tick("amp");
        chk("amp_off", 32'(bus.amp_en), 0);

        // Pin input latency and glitch handling
        for (int i = 0; i < 6; i++) tick("pin");
        pin_i = 32'hA5A5_A5A5;
        lat   = -1;
        for (int i = 1; i <= 8; i++) begin
            tick("pin");
            if (lat < 0 && bus.pin_in_core == 32'hA5A5_A5A5) lat = i;
        end
`ifdef BOARD_IO_GLITCH_FILTER_EN
        chk("pin_lat", lat, SYNC + 2);
`else
        chk("pin_lat", lat, SYNC);
`endif
        pin_i = 32'hA5A5_A5A4;
        tick("glitch");
        pin_i = 32'hA5A5_A5A5;
        saw   = 1'b0;
        for (int i = 0; i < 8; i++) begin
            tick("glitch");
            if (!bus.pin_in_core[0]) saw = 1'b1;
        end
`ifdef BOARD_IO_GLITCH_FILTER_EN
        chk("glitch_seen", 32'(saw), 0);
`else
        chk("glitch_seen", 32'(saw), 1);
`endif

        // LED stretch: single pulse, then a retrigger halfway
        cog_led_in = 8'h08;
        hi         = 0;
        other      = 1'b0;
        tick("led");
        cog_led_in = '0;
        if (bus.led[3]) hi++;
        for (int i = 0; i < LS + 100; i++) begin
            tick("led");
            if (bus.led[3]) hi++;
            if ((bus.led & 8'hF7) != 0) other = 1'b1;
        end
        chk("led_len", hi, LS);
        chk("led_other", 32'(other), 0);
        hi = 0;
        for (int i = 0; i < LS + LS / 2 + 100; i++) begin
            cog_led_in = (i == 0 || i == LS / 2) ? 8'h08 : 8'h00;
            tick("led2");
            if (bus.led[3]) hi++;
        end
        chk("led_retrig", hi, LS + LS / 2);

        // Configuration halt and recovery
        cfg_halt = 1'b1;
        tick("halt");
        chk("halt_nres", 32'(bus.nres), 0);
        cfg_halt = 1'b0;
        rise     = -1;
        for (int i = 1; i <= 24; i++) begin
            tick("halt");
            if (rise < 0 && bus.nres) rise = i;
        end
        chk("halt_rec", rise, HOLD);

        // Asynchronous reset in the middle of a hold count
        pin_dir_core = '1;
        cog_led_in   = 8'hFF;
        tick("arst");
        cog_led_in = '0;
        cfg_halt   = 1'b1;
        tick("arst");
        cfg_halt = 1'b0;
        for (int i = 0; i < 5; i++) tick("arst");
        #2;
        res = 1'b1;
        #1;
        model_reset();
        check_all("arst_now");
        @(negedge clk_cog);
        for (int i = 0; i < 2; i++) tick("arst");
        res = 1'b0;

        // Random traffic
        for (int i = 0; i < 3000; i++) begin
            rts       = ($urandom_range(0, 199) != 0);
            ext_res_n = ($urandom_range(0, 299) != 0);
            cfg_halt  = ($urandom_range(0, 249) == 0);
            if ($urandom_range(0, 3) == 0) pin_i = $urandom;
            pin_out_core = $urandom;
            pin_dir_core = $urandom;
            cog_led_in   = ($urandom_range(0, 49) == 0) ? 8'($urandom) : 8'h00;
            tick("rand");
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule

// File: doc/board_io_ring.md
Name: board_io_ring

Overview:
Parametrised board I/O ring that sits between the FPGA pads and the Propeller core (`dig`) in every board top level. It replaces hand-wired reset gating, pin tristating and LED wiring with a single block that provides:
- a reset sequencer with hold-off counter;
- N-pin input synchronisers;
- registered, reset-safe pin output enables;
- per-LED activity stretchers;
- amplifier enable derived from a selectable pin.
Board tops only add the tristate assignment (pad = pin_oe ? pin_o : Z).

Parameters:
NUM_PINS, 32, number of Propeller I/O pins.
SYNC_STAGES, 2, synchroniser depth for pins and external reset inputs; must be >= 2.
RESET_HOLD, 16, clk_cog cycles nres is held low after all reset sources clear; must be >= 1.
NUM_LEDS, 8, number of LED channels.
LED_STRETCH, 1000, cycles an LED stays lit after its input goes low; must be >= 1.
AMP_PIN, 10, pin index whose output enable drives amp_en.

Ports:
clk_cog  in  1  core clock; all logic is on this clock.
res  in  1  asynchronous, active-high reset.
rts  in  1  serial RTS; active-low reset request; asynchronous.
ext_res_n  in  1  board reset button; active low; asynchronous.
cfg_halt  in  1  core cfg[7]; 1 forces core reset.
nres  out  1  active-low core reset.
pin_i  in  NUM_PINS  raw pad inputs.
pin_in_core  out  NUM_PINS  synchronised pin inputs to core.
pin_out_core  in  NUM_PINS  core output values.
pin_dir_core  in  NUM_PINS  core direction bits; 1 = output.
pin_o  out  NUM_PINS  registered pad output value.
pin_oe  out  NUM_PINS  registered pad output enable.
cog_led_in  in  NUM_LEDS  raw cog activity.
led  out  NUM_LEDS  stretched LED drive.
amp_en  out  1  audio amplifier enable.

Behaviour:
- Reset values while res=1:
  - nres=0, pin_o=0, pin_oe=0, pin_in_core=0, led=0, amp_en=0.
  - Synchroniser flops for rts and ext_res_n reset to the "request active" state.
  - Pin synchronisers reset to 0.
- Reset request trigger = synced(~rts) | synced(~ext_res_n), each passed through SYNC_STAGES flops.
- Sequencer FSM, reset state HOLD with count=0. Hold counter width is $clog2(RESET_HOLD+1).
  - HOLD:
    - nres=0.
    - trigger or cfg_halt → count=0 and stay in HOLD.
    - Otherwise count++.
    - When count==RESET_HOLD-1 with no trigger/halt → RUN.
  - RUN:
    - nres=1.
    - trigger or cfg_halt → HOLD with count=0; nres=0 from the next edge.
- Resulting latency: with rts=ext_res_n=1 and cfg_halt=0, nres rises on edge SYNC_STAGES+RESET_HOLD after res deasserts.
- res asserted mid-operation → every output returns to its reset value immediately (asynchronous reset).
- Pin outputs, registered with 1-cycle latency:
  - pin_o <= pin_out_core.
  - pin_oe <= nres ? pin_dir_core : 0. All pins are inputs whenever the core is in reset.
- amp_en <= nres & pin_dir_core[AMP_PIN], i.e. the same timing as pin_oe[AMP_PIN].
- Pin inputs: pin_in_core = pin_i delayed by SYNC_STAGES clk_cog edges. No gating by nres.
- LED stretcher, per channel:
  - cnt width is $clog2(LED_STRETCH+1).
  - cog_led_in=1 → cnt<=LED_STRETCH.
  - Otherwise, if cnt!=0, cnt<=cnt-1.
  - led = (cnt!=0), driven from the register.
  - A 1-cycle input pulse gives exactly LED_STRETCH high cycles, starting at the edge after the pulse.
  - Retriggering while lit reloads cnt; no saturation issues.

Optional Feature:
Macro BOARD_IO_GLITCH_FILTER_EN.
- Defined:
  - Each synchronised pin feeds a 3-sample stability filter.
  - pin_in_core[k] updates only when the last 3 synchronised samples agree.
  - Latency becomes SYNC_STAGES+2 edges; pulses shorter than 3 cycles are rejected.
  - Filter registers reset to 0.
- Undefined: no filter logic is instantiated; latency is SYNC_STAGES.

Test Plan:
1. Defaults, res 1→0 with rts=1, ext_res_n=1, cfg_halt=0 → nres=0 through edge 17, nres=1 from edge 18; pin_oe=0 throughout hold even with pin_dir_core=0xFFFFFFFF.
2. RUN, rts low for 1 cycle → nres falls within SYNC_STAGES+1=3 edges, stays 0 for 16 cycles after the synced request clears, then returns to 1; pin_oe=0 during the low phase.
3. RUN, pin_dir_core=0x00000400, pin_out_core=0x00000400 → one edge later pin_oe=0x400, pin_o=0x400, amp_en=1; dir cleared → amp_en=0 one edge later.
4. pin_i 0→0xA5A5A5A5 → pin_in_core=0xA5A5A5A5 after 2 edges (4 with BOARD_IO_GLITCH_FILTER_EN). A 1-cycle glitch on pin_i[0] appears on pin_in_core without the filter and is absent with it.
5. cog_led_in[3] pulsed for 1 cycle, LED_STRETCH=1000 → led[3] high exactly 1000 cycles; other LEDs stay 0. A second pulse at cycle 500 extends high time to 1500 total.
6. RUN, cfg_halt=1 → nres=0 next edge; cfg_halt=0 → nres=1 after 16 edges. res asserted mid-count → all outputs 0 immediately.
